lsu: RTL and testbench

Load/store unit sitting on the receiving end of the execute-stage interface: it consumes `exe_to_mem_t` beats, issues data-memory requests over a req/gnt/rvalid handshake, aligns and extends load data, and presents a registered `mem_to_wb_t` to writeback. While a memory access is in flight it asserts `stall_o` to freeze execute and earlier stages. Non-memory instructions pass through with one cycle of latency.

---
 rtl/tartaruga_pkg.sv | 57 +++++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu.sv | 130 +++++++++++++
 tb/tb_lsu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga pipeline: execute-to-memory and memory-to-writeback
// beats, memory operation encodings and the load/store unit state.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        mem_op_t    mem_op;
        mem_size_t  mem_size;
        logic       mem_unsigned;
    } instr_t;

    typedef struct packed {
        logic   valid;
        instr_t instr;
        bus32_t result;
        bus32_t data_rs2;
        logic   branch_taken;
    } exe_to_mem_t;

    typedef struct packed {
        logic   valid;
        instr_t instr;
        bus32_t result;
        logic   branch_taken;
        logic   misaligned;
    } mem_to_wb_t;

    localparam instr_t NOP_INSTR = '{
        opcode: 7'd0, rd: 5'd0, mem_op: MEM_NONE, mem_size: BYTE, mem_unsigned: 1'b0
    };

    localparam mem_to_wb_t NOP_MEM_TO_WB = '{
        valid: 1'b0, instr: NOP_INSTR, result: 32'd0, branch_taken: 1'b0, misaligned: 1'b0
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, load lane
// extraction with sign/zero extension, and alignment check.
module lsu_align
    import tartaruga_pkg::*;
(
    input  mem_size_t  size,
    input  logic [1:0] addr_lo,
    input  logic       is_unsigned,
    input  bus32_t     rs2,
    input  bus32_t     rdata,
    output logic [3:0] be,
    output bus32_t     wdata,
    output bus32_t     load_data,
    output logic       misaligned
);

    bus32_t shifted;

    always_comb begin
        // Bring the addressed lane down to bit 0 before extending.
        shifted    = rdata >> {addr_lo, 3'b000};
        be         = 4'b0000;
        wdata      = rs2;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{rs2[7:0]}};
                load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{rs2[15:0]}};
                load_data  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            WORD: begin
                be         = 4'b1111;
                wdata      = rs2;
                load_data  = rdata;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts execute beats, runs the dmem req/gnt/rvalid handshake
// and presents a registered writeback beat; stalls upstream while an access is open.
module lsu
    import tartaruga_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  exe_to_mem_t exe_to_mem_i,
    output mem_to_wb_t  mem_to_wb_o,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output bus32_t      dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output bus32_t      dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  bus32_t      dmem_rdata_i
);

    lsu_state_t state, state_next;
    mem_to_wb_t wb_q, wb_next;
    instr_t     hold_instr;
    bus32_t     hold_addr;
    bus32_t     hold_rs2;
    logic       hold_bt;
    logic       capture;

    mem_size_t  sel_size;
    logic [1:0] sel_addr_lo;
    logic       sel_unsigned;
    bus32_t     sel_rs2;
    bus32_t     load_data;
    logic       misaligned;

    // In IDLE the aligner checks the incoming beat; otherwise it serves the held access.
    always_comb begin
        if (state == IDLE) begin
            sel_size     = exe_to_mem_i.instr.mem_size;
            sel_addr_lo  = exe_to_mem_i.result[1:0];
            sel_unsigned = exe_to_mem_i.instr.mem_unsigned;
            sel_rs2      = exe_to_mem_i.data_rs2;
        end else begin
            sel_size     = hold_instr.mem_size;
            sel_addr_lo  = hold_addr[1:0];
            sel_unsigned = hold_instr.mem_unsigned;
            sel_rs2      = hold_rs2;
        end
    end

    lsu_align u_align (
        .size        (sel_size),
        .addr_lo     (sel_addr_lo),
        .is_unsigned (sel_unsigned),
        .rs2         (sel_rs2),
        .rdata       (dmem_rdata_i),
        .be          (dmem_be_o),
        .wdata       (dmem_wdata_o),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_next = state;
        wb_next    = NOP_MEM_TO_WB;
        capture    = 1'b0;
        dmem_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (exe_to_mem_i.valid) begin
                    if (exe_to_mem_i.instr.mem_op == MEM_NONE || misaligned) begin
                        wb_next = '{valid: 1'b1, instr: exe_to_mem_i.instr,
                                    result: exe_to_mem_i.result,
                                    branch_taken: exe_to_mem_i.branch_taken,
                                    misaligned: (exe_to_mem_i.instr.mem_op != MEM_NONE)};
                    end else begin
                        capture    = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                dmem_req_o = 1'b1;
                if (dmem_gnt_i) begin
                    if (hold_instr.mem_op == MEM_STORE) begin
                        state_next = IDLE;
                        wb_next    = '{valid: 1'b1, instr: hold_instr, result: hold_addr,
                                       branch_taken: hold_bt, misaligned: 1'b0};
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_next = IDLE;
                    wb_next    = '{valid: 1'b1, instr: hold_instr, result: load_data,
                                   branch_taken: hold_bt, misaligned: 1'b0};
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            wb_q       <= NOP_MEM_TO_WB;
            hold_instr <= NOP_INSTR;
            hold_addr  <= '0;
            hold_rs2   <= '0;
            hold_bt    <= 1'b0;
        end else begin
            state <= state_next;
            wb_q  <= wb_next;
            if (capture) begin
                hold_instr <= exe_to_mem_i.instr;
                hold_addr  <= exe_to_mem_i.result;
                hold_rs2   <= exe_to_mem_i.data_rs2;
                hold_bt    <= exe_to_mem_i.branch_taken;
            end
        end
    end

    assign mem_to_wb_o = wb_q;
    assign stall_o     = (state != IDLE);
    assign dmem_we_o   = (hold_instr.mem_op == MEM_STORE);
    assign dmem_addr_o = {hold_addr[31:2], 2'b00};

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized instructions checked
// against an arithmetic reference of the load/store rules.
module tb_lsu;
    import tartaruga_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    exe_to_mem_t ein;
    mem_to_wb_t  wb;
    logic        stall, req, we, gnt, rvalid;
    logic [31:0] addr_o, wdata_o, rdata;
    logic [3:0]  be_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .exe_to_mem_i  (ein),
        .mem_to_wb_o   (wb),
        .stall_o       (stall),
        .dmem_req_o    (req),
        .dmem_we_o     (we),
        .dmem_addr_o   (addr_o),
        .dmem_be_o     (be_o),
        .dmem_wdata_o  (wdata_o),
        .dmem_gnt_i    (gnt),
        .dmem_rvalid_i (rvalid),
        .dmem_rdata_i  (rdata)
    );

    task automatic check(input string tag, input string what, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic is_mis(input mem_size_t s, input logic [1:0] a);
        if (s == HALF) return (a % 2) != 0;
        if (s == WORD) return a != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_be(input mem_size_t s, input logic [1:0] a);
        if (s == BYTE) return 32'd1 << a;
        if (s == HALF) return 32'd3 << a;
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input mem_size_t s, input logic [31:0] d);
        if (s == BYTE) return (d % 256) * 32'h0101_0101;
        if (s == HALF) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input mem_size_t s, input logic u,
                                             input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * a);
        if (s == BYTE) begin
            v = v % 256;
            if (!u && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (s == HALF) begin
            v = v % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Drives one instruction from an idle unit to completion, checking every cycle.
    task automatic run_instr(input string tag, input mem_op_t op, input mem_size_t sz,
                             input logic u, input logic [31:0] a, input logic [31:0] rs2,
                             input int gd, input int rvd, input logic [31:0] rd_word);
        instr_t      ins;
        logic        bt, mis;
        logic [31:0] exp_res;
        ins.opcode       = 7'($urandom);
        ins.rd           = 5'($urandom);
        ins.mem_op       = op;
        ins.mem_size     = sz;
        ins.mem_unsigned = u;
        bt  = 1'($urandom);
        mis = (op != MEM_NONE) && is_mis(sz, a[1:0]);
        exp_res = a;
        ein.valid = 1'b1; ein.instr = ins; ein.result = a;
        ein.data_rs2 = rs2; ein.branch_taken = bt;
        check(tag, "stall_accept", 32'(stall), 32'd0);
        cyc();
        ein.valid = 1'b0;
        if (op != MEM_NONE && !mis) begin
            for (int i = 0; i <= gd; i++) begin
                check(tag, "req", 32'(req), 32'd1);
                check(tag, "stall_req", 32'(stall), 32'd1);
                check(tag, "addr", addr_o, a & 32'hFFFF_FFFC);
                check(tag, "we", 32'(we), 32'(op == MEM_STORE));
                check(tag, "be", 32'(be_o), ref_be(sz, a[1:0]));
                if (op == MEM_STORE) check(tag, "wdata", wdata_o, ref_wdata(sz, rs2));
                check(tag, "wb_quiet_req", 32'(wb.valid), 32'd0);
                if (i == gd) begin
                    gnt = 1'b1;
                    rvalid = 1'($urandom);
                end
                cyc();
                gnt = 1'b0; rvalid = 1'b0;
            end
            if (op == MEM_LOAD) begin
                for (int i = 0; i <= rvd; i++) begin
                    check(tag, "req_wait", 32'(req), 32'd0);
                    check(tag, "stall_wait", 32'(stall), 32'd1);
                    check(tag, "wb_quiet_wait", 32'(wb.valid), 32'd0);
                    rvalid = (i == rvd);
                    rdata  = (i == rvd) ? rd_word : $urandom;
                    cyc();
                    rvalid = 1'b0;
                end
                exp_res = ref_load(sz, u, a[1:0], rd_word);
            end
        end else begin
            check(tag, "no_req", 32'(req), 32'd0);
        end
        check(tag, "wb_valid", 32'(wb.valid), 32'd1);
        check(tag, "wb_result", wb.result, exp_res);
        check(tag, "wb_mis", 32'(wb.misaligned), 32'(mis));
        check(tag, "wb_instr", 32'(wb.instr), 32'(ins));
        check(tag, "wb_bt", 32'(wb.branch_taken), 32'(bt));
        check(tag, "stall_done", 32'(stall), 32'd0);
        cyc();
        check(tag, "wb_pulse", 32'(wb.valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        mem_op_t     op;
        mem_size_t   sz;
        ein = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;

        // Reset state
        #1;
        check("reset", "wb_valid", 32'(wb.valid), 32'd0);
        check("reset", "wb_mis", 32'(wb.misaligned), 32'd0);
        check("reset", "wb_bt", 32'(wb.branch_taken), 32'd0);
        check("reset", "req", 32'(req), 32'd0);
        check("reset", "stall", 32'(stall), 32'd0);
        cyc(); cyc();
        rstn = 1'b1;
        cyc();

        run_instr("alu", MEM_NONE, WORD, 1'b0, 32'h1234_5678, 32'h0, 0, 0, 32'h0);
        run_instr("sb", MEM_STORE, BYTE, 1'b0, 32'h0000_0103, 32'h0000_00AB, 2, 0, 32'h0);
        run_instr("lh", MEM_LOAD, HALF, 1'b0, 32'h0000_0202, 32'h0, 0, 0, 32'h80FF_0000);
        run_instr("lhu", MEM_LOAD, HALF, 1'b1, 32'h0000_0202, 32'h0, 1, 2, 32'h80FF_0000);
        run_instr("lb", MEM_LOAD, BYTE, 1'b0, 32'h0000_0203, 32'h0, 0, 1, 32'h80FF_0000);
        run_instr("lw_mis", MEM_LOAD, WORD, 1'b0, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
        run_instr("sw", MEM_STORE, WORD, 1'b0, 32'hDEAD_BEE0, 32'hCAFE_F00D, 0, 0, 32'h0);

        // Handshake inputs while idle must be ignored
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'h5555_AAAA;
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        check("idle_hs", "wb_valid", 32'(wb.valid), 32'd0);
        check("idle_hs", "req", 32'(req), 32'd0);
        check("idle_hs", "stall", 32'(stall), 32'd0);

        // Load followed by an ALU op held on the input during the stall
        ein.valid = 1'b1; ein.instr = NOP_INSTR; ein.instr.mem_op = MEM_LOAD;
        ein.instr.mem_size = WORD; ein.result = 32'h0000_0400; ein.branch_taken = 1'b0;
        cyc();
        ein.instr = NOP_INSTR; ein.instr.rd = 5'd7; ein.result = 32'h0BAD_CAFE;
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        check("b2b", "stall_wait", 32'(stall), 32'd1);
        check("b2b", "wb_quiet", 32'(wb.valid), 32'd0);
        rvalid = 1'b1; rdata = 32'h1357_9BDF;
        cyc();
        rvalid = 1'b0;
        check("b2b", "load_valid", 32'(wb.valid), 32'd1);
        check("b2b", "load_result", wb.result, 32'h1357_9BDF);
        check("b2b", "stall_idle", 32'(stall), 32'd0);
        cyc();
        ein.valid = 1'b0;
        check("b2b", "alu_valid", 32'(wb.valid), 32'd1);
        check("b2b", "alu_result", wb.result, 32'h0BAD_CAFE);
        check("b2b", "alu_rd", 32'(wb.instr.rd), 32'd7);
        cyc();
        check("b2b", "alu_pulse", 32'(wb.valid), 32'd0);

        // Reset while waiting for load data
        ein.valid = 1'b1; ein.instr = NOP_INSTR; ein.instr.mem_op = MEM_LOAD;
        ein.instr.mem_size = WORD; ein.result = 32'h0000_0800;
        cyc();
        ein.valid = 1'b0;
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        check("rst_wait", "stall_pre", 32'(stall), 32'd1);
        rstn = 1'b0;
        #1;
        check("rst_wait", "req", 32'(req), 32'd0);
        check("rst_wait", "stall", 32'(stall), 32'd0);
        check("rst_wait", "wb_valid", 32'(wb.valid), 32'd0);
        cyc();
        rstn = 1'b1;
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        cyc();
        rvalid = 1'b0;
        check("rst_wait", "late_rvalid", 32'(wb.valid), 32'd0);
        check("rst_wait", "stall_after", 32'(stall), 32'd0);
        cyc();
        check("rst_wait", "late_rvalid2", 32'(wb.valid), 32'd0);

        // Randomized instruction mix
        for (int k = 0; k < 60; k++) begin
            op = mem_op_t'($urandom_range(0, 2));
            sz = mem_size_t'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == HALF) a[0] = 1'b0;
                if (sz == WORD) a[1:0] = 2'b00;
            end
            run_instr("rand", op, sz, 1'($urandom), a, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
